// File: rtl/amradio_safety_pkg.sv
// Shared types for the AM radio RF safety path: shutdown FSM state encoding and counter widths.
package amradio_safety_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned FAULT_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN       = 3'd0,
        ST_RAMP_DOWN = 3'd1,
        ST_MUTED     = 3'd2,
        ST_HOLDOFF   = 3'd3,
        ST_RAMP_UP   = 3'd4
    } ssd_state_e;

    // RF stays enabled while a carrier is (or may be) present at the modulator.
    function automatic logic rf_active(input ssd_state_e s);
        return (s == ST_RUN) || (s == ST_RAMP_DOWN) || (s == ST_RAMP_UP);
    endfunction

endpackage

// File: rtl/amp_ramp.sv
// Combinational single-step amplitude ramp toward a target, saturating at the target with no wrap.
module amp_ramp #(
    parameter int unsigned AMP_W     = 16,
    parameter int unsigned RAMP_STEP = 256
) (
    input  logic [AMP_W-1:0] cur,
    input  logic [AMP_W-1:0] target,
    input  logic             dir_up,
    output logic [AMP_W-1:0] nxt_c,
    output logic             at_target_c
);

    localparam logic [AMP_W:0]   STEP_X = (AMP_W+1)'(RAMP_STEP);
    localparam logic [AMP_W-1:0] STEP   = AMP_W'(RAMP_STEP);

    logic [AMP_W-1:0] gap;

    // Snap onto the target when within one step, or when already past it in the ramp direction.
    always_comb begin
        nxt_c = target;
        gap   = '0;
        if (dir_up) begin
            if (cur < target) begin
                gap = target - cur;
                if ({1'b0, gap} > STEP_X) nxt_c = cur + STEP;
            end
        end else begin
            if (cur > target) begin
                gap = cur - target;
                if ({1'b0, gap} > STEP_X) nxt_c = cur - STEP;
            end
        end
    end

    assign at_target_c = (nxt_c == target);

endmodule

// File: rtl/safe_shutdown_ctrl.sv
// RF safe-shutdown controller: ramps the carrier down on watchdog faults, mutes, holds off, ramps back up.
// Define AUTO_RECOVER_EN to leave HOLDOFF without waiting for clear_fault.
module safe_shutdown_ctrl
    import amradio_safety_pkg::*;
#(
    parameter int unsigned AMP_W          = 16,
    parameter int unsigned RAMP_STEP      = 256,
    parameter int unsigned HOLDOFF_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   force_reset,
    input  logic                   warning,
    input  logic                   clear_fault,
    input  logic [AMP_W-1:0]       amp_in,
    output logic [AMP_W-1:0]       amp_out,
    output logic                   rf_enable,
    output logic                   fault_latched,
    output logic [FAULT_CNT_W-1:0] fault_count,
    output logic [STATE_W-1:0]     state
);

    localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_RELOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [FAULT_CNT_W-1:0] CNT_MAX     = {FAULT_CNT_W{1'b1}};

    ssd_state_e             state_q, state_d;
    logic [AMP_W-1:0]       amp_d;
    logic                   rf_d;
    logic                   lat_d;
    logic [FAULT_CNT_W-1:0] cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   fault_set;
    logic                   fault_clr;
    logic                   recover_ok;
    logic                   ramp_up_sel;
    logic [AMP_W-1:0]       ramp_target;
    logic [AMP_W-1:0]       ramp_nxt_c;
    logic                   ramp_done_c;

    assign state = state_q;

    // Ramp down always aims at zero; ramp up tracks the live amp_in request.
    assign ramp_up_sel = (state_q == ST_RAMP_UP);
    assign ramp_target = ramp_up_sel ? amp_in : '0;

    amp_ramp #(
        .AMP_W     (AMP_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_amp_ramp (
        .cur         (amp_out),
        .target      (ramp_target),
        .dir_up      (ramp_up_sel),
        .nxt_c       (ramp_nxt_c),
        .at_target_c (ramp_done_c)
    );

`ifdef AUTO_RECOVER_EN
    assign recover_ok = (hold_q == '0);
`else
    assign recover_ok = (hold_q == '0) && !fault_latched;
`endif

    // Next-state, next-amplitude and fault bookkeeping.
    always_comb begin
        state_d   = state_q;
        amp_d     = amp_out;
        hold_d    = hold_q;
        fault_set = 1'b0;
        fault_clr = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (force_reset) begin
                    state_d   = ST_RAMP_DOWN;
                    fault_set = 1'b1;
                end else begin
                    amp_d = warning ? (amp_in >> 1) : amp_in;
                end
            end
            ST_RAMP_DOWN: begin
                amp_d = ramp_nxt_c;
                if (ramp_done_c) state_d = ST_MUTED;
            end
            ST_MUTED: begin
                amp_d = '0;
                if (!force_reset) begin
                    state_d = ST_HOLDOFF;
                    hold_d  = HOLD_RELOAD;
                end
            end
            ST_HOLDOFF: begin
                amp_d = '0;
                if (force_reset) begin
                    state_d = ST_MUTED;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (recover_ok) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (force_reset) begin
                    state_d   = ST_RAMP_DOWN;
                    fault_set = 1'b1;
                end else begin
                    amp_d = ramp_nxt_c;
                    if (ramp_done_c) state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RAMP_UP;
                amp_d   = '0;
                hold_d  = '0;
            end
        endcase

        // force_reset always wins over a same-cycle acknowledge.
        fault_clr = clear_fault && !force_reset &&
                    ((state_q == ST_RUN) || (state_q == ST_RAMP_UP) || (state_q == ST_HOLDOFF));
        lat_d     = fault_set || (fault_latched && !fault_clr);
        cnt_d     = (fault_set && (fault_count != CNT_MAX)) ? fault_count + FAULT_CNT_W'(1) : fault_count;
        rf_d      = rf_active(state_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_RAMP_UP;
            amp_out       <= '0;
            rf_enable     <= 1'b0;
            fault_latched <= 1'b0;
            fault_count   <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            amp_out       <= amp_d;
            rf_enable     <= rf_d;
            fault_latched <= lat_d;
            fault_count   <= cnt_d;
            hold_q        <= hold_d;
        end
    end

endmodule

// File: tb/tb_safe_shutdown_ctrl.sv
// Self-checking bench for safe_shutdown_ctrl: cycle model feeds an expected-output queue, plus directed scenario checks.
module tb_safe_shutdown_ctrl;

    localparam int unsigned AMP_W          = 16;
    localparam int unsigned RAMP_STEP      = 256;
    localparam int unsigned HOLDOFF_CYCLES = 16;

    localparam int S_RUN = 0;
    localparam int S_RD  = 1;
    localparam int S_MU  = 2;
    localparam int S_HO  = 3;
    localparam int S_RU  = 4;

    typedef struct packed {
        logic [2:0]       st;
        logic [AMP_W-1:0] amp;
        logic             rf;
        logic             lat;
        logic [7:0]       cnt;
    } obs_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             force_reset;
    logic             warning;
    logic             clear_fault;
    logic [AMP_W-1:0] amp_in;
    logic [AMP_W-1:0] amp_out;
    logic             rf_enable;
    logic             fault_latched;
    logic [7:0]       fault_count;
    logic [2:0]       state;

    safe_shutdown_ctrl #(
        .AMP_W          (AMP_W),
        .RAMP_STEP      (RAMP_STEP),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .force_reset   (force_reset),
        .warning       (warning),
        .clear_fault   (clear_fault),
        .amp_in        (amp_in),
        .amp_out       (amp_out),
        .rf_enable     (rf_enable),
        .fault_latched (fault_latched),
        .fault_count   (fault_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t sb_q[$];

    int   m_state, m_amp, m_hold, m_cnt;
    bit   m_lat, m_rf;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Behavioural reference: one clock of the shutdown sequence from the current inputs.
    task automatic model_step();
        int  st_old = m_state;
        int  a_in   = int'(amp_in);
        bit  accept = 1'b0;
        bit  recov;
`ifdef AUTO_RECOVER_EN
        recov = 1'b1;
`else
        recov = !m_lat;
`endif
        case (st_old)
            S_RUN: begin
                if (force_reset) begin m_state = S_RD; accept = 1'b1; end
                else m_amp = warning ? (a_in / 2) : a_in;
            end
            S_RD: begin
                m_amp = (m_amp > int'(RAMP_STEP)) ? m_amp - int'(RAMP_STEP) : 0;
                if (m_amp == 0) m_state = S_MU;
            end
            S_MU: begin
                m_amp = 0;
                if (!force_reset) begin m_state = S_HO; m_hold = HOLDOFF_CYCLES - 1; end
            end
            S_HO: begin
                m_amp = 0;
                if (force_reset) m_state = S_MU;
                else if (m_hold > 0) m_hold--;
                else if (recov) m_state = S_RU;
            end
            default: begin
                if (force_reset) begin m_state = S_RD; accept = 1'b1; end
                else begin
                    if (a_in <= m_amp || a_in - m_amp <= int'(RAMP_STEP)) m_amp = a_in;
                    else m_amp = m_amp + int'(RAMP_STEP);
                    if (m_amp == a_in) m_state = S_RUN;
                end
            end
        endcase
        if (clear_fault && !force_reset && (st_old == S_RUN || st_old == S_RU || st_old == S_HO))
            m_lat = 1'b0;
        if (accept) begin
            m_lat = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        m_rf = (m_state == S_RUN) || (m_state == S_RD) || (m_state == S_RU);
    endtask

    task automatic tick();
        obs_t e;
        model_step();
        e.st  = 3'(m_state);
        e.amp = AMP_W'(m_amp);
        e.rf  = m_rf;
        e.lat = m_lat;
        e.cnt = 8'(m_cnt);
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Scoreboard: compare every clocked result half a cycle after the edge.
    always @(negedge clk) begin : mon
        obs_t e;
        if (rstn === 1'b1 && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("state",         64'(state),         64'(e.st));
            check_eq("amp_out",       64'(amp_out),       64'(e.amp));
            check_eq("rf_enable",     64'(rf_enable),     64'(e.rf));
            check_eq("fault_latched", 64'(fault_latched), 64'(e.lat));
            check_eq("fault_count",   64'(fault_count),   64'(e.cnt));
        end
    end

    task automatic do_reset(input bit frc);
        #2;
        rstn        = 1'b0;
        force_reset = frc;
        clear_fault = 1'b0;
        #1;
        m_state = S_RU; m_amp = 0; m_rf = 1'b0; m_lat = 1'b0; m_cnt = 0; m_hold = 0;
        check_eq("rst_state", 64'(state),         64'(S_RU));
        check_eq("rst_amp",   64'(amp_out),       64'(0));
        check_eq("rst_rf",    64'(rf_enable),     64'(0));
        check_eq("rst_lat",   64'(fault_latched), 64'(0));
        check_eq("rst_cnt",   64'(fault_count),   64'(0));
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic tick_until(input int st, input int max_ticks, output int n);
        n = 0;
        while (int'(state) != st && n < max_ticks) begin
            tick();
            n++;
        end
    endtask

    // Acknowledge on HOLDOFF entry and measure how many clocks HOLDOFF lasts.
    task automatic run_holdoff(output int n);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        n = 1;
        while (int'(state) == S_HO && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic fault_to_holdoff();
        int n;
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        tick_until(S_HO, 40, n);
        check_eq("reach_holdoff", 64'(state), 64'(S_HO));
    endtask

    initial begin
        int n;
        logic [AMP_W-1:0] pre_amp;
        rstn = 1'b1; force_reset = 1'b0; warning = 1'b0; clear_fault = 1'b0; amp_in = 16'h1000;
        do_reset(1'b0);

        // Power-up ramp: 16 steps of 0x100 to 0x1000.
        tick();
        check_eq("rf_first_clk", 64'(rf_enable), 64'(1));
        for (int i = 0; i < 15; i++) tick();
        check_eq("pwrup_state", 64'(state),   64'(S_RUN));
        check_eq("pwrup_amp",   64'(amp_out), 64'(16'h1000));

        // Warning halves the carrier in RUN.
        amp_in = 16'h2000; tick();
        warning = 1'b1; tick();
        check_eq("warn_half", 64'(amp_out), 64'(16'h1000));
        warning = 1'b0; tick();
        check_eq("warn_drop", 64'(amp_out), 64'(16'h2000));

        // Single fault from 0x0900: nine down steps, mute, 16 holdoff clocks, ramp back.
        amp_in = 16'h0900; tick();
        force_reset = 1'b1; tick(); force_reset = 1'b0;
        check_eq("enter_rd",  64'(state),       64'(S_RD));
        check_eq("cnt_one",   64'(fault_count), 64'(1));
        tick_until(S_MU, 20, n);
        check_eq("rd_steps",  64'(n),           64'(9));
        check_eq("muted_amp", 64'(amp_out),     64'(0));
        check_eq("muted_rf",  64'(rf_enable),   64'(0));
        tick();
        check_eq("enter_ho",  64'(state),       64'(S_HO));
        run_holdoff(n);
        check_eq("holdoff_len", 64'(n),         64'(16));
        tick_until(S_RUN, 20, n);
        check_eq("ru_steps",  64'(n),           64'(9));

        // Fault re-asserted mid-holdoff: back to MUTED, full reload, no extra count.
        fault_to_holdoff();
        for (int i = 0; i < 10; i++) tick();
        force_reset = 1'b1; tick();
        check_eq("ho_remute",  64'(state),       64'(S_MU));
        check_eq("cnt_no_inc", 64'(fault_count), 64'(2));
        force_reset = 1'b0; tick();
        run_holdoff(n);
        check_eq("holdoff_reload", 64'(n), 64'(16));
        tick_until(S_RUN, 20, n);

        // Recovery gating by acknowledge.
        fault_to_holdoff();
        for (int i = 0; i < 40; i++) tick();
`ifdef AUTO_RECOVER_EN
        check_eq("auto_recover", 64'(state), 64'(S_RUN));
`else
        check_eq("ho_wait_ack", 64'(state), 64'(S_HO));
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        tick();
        check_eq("recover_after_clear", 64'(state), 64'(S_RU));
        tick_until(S_RUN, 20, n);
`endif

        // amp_in dropped below a ramping amp_out snaps down; warning ignored outside RUN.
        fault_to_holdoff();
        run_holdoff(n);
        amp_in = 16'h4000; warning = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("ru_partial", 64'(amp_out), 64'(16'h0400));
        amp_in = 16'h0200; tick();
        check_eq("clamp_amp",   64'(amp_out), 64'(16'h0200));
        check_eq("clamp_state", 64'(state),   64'(S_RUN));
        warning = 1'b0;

        // Fault counter saturation.
        amp_in = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            fault_to_holdoff();
            run_holdoff(n);
            tick_until(S_RUN, 10, n);
        end
        check_eq("cnt_sat", 64'(fault_count), 64'(255));

        // force_reset beats a simultaneous acknowledge; acknowledge ignored while MUTED.
        force_reset = 1'b1; clear_fault = 1'b1; tick();
        check_eq("force_beats_clear", 64'(fault_latched), 64'(1));
        clear_fault = 1'b0; force_reset = 1'b0;
        tick_until(S_HO, 10, n);
        force_reset = 1'b1; clear_fault = 1'b1; tick();
        check_eq("ho_force_clear", 64'(fault_latched), 64'(1));
        force_reset = 1'b0; tick();
        check_eq("clear_ignored_muted", 64'(fault_latched), 64'(1));
        clear_fault = 1'b0;
        run_holdoff(n);

        // Reset mid-ramp, released with force_reset held high.
        amp_in = 16'h4000;
        for (int i = 0; i < 5; i++) tick();
        pre_amp = amp_out;
        check_eq("pre_rst_amp", 64'(pre_amp), 64'(16'h0500));
        do_reset(1'b1);
        tick();
        check_eq("frc_rel_rd",  64'(state),     64'(S_RD));
        check_eq("frc_rel_amp", 64'(amp_out),   64'(0));
        force_reset = 1'b0;
        tick();
        check_eq("frc_rel_mu",  64'(state),     64'(S_MU));
        tick();
        tick();

        @(negedge clk);
        check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/safe_shutdown_ctrl.md
SAFE_SHUTDOWN_CTRL -- requirements
Module: safe_shutdown_ctrl

Interface
REQ-001 The block SHALL have parameter AMP_W, default 16, meaning the amplitude word width.
REQ-002 The block SHALL have parameter RAMP_STEP, default 256, meaning the amplitude change per clock during ramps.
REQ-003 The block SHALL have parameter HOLDOFF_CYCLES, default 1024, meaning the quiet time after force_reset drops.
REQ-004 The block SHALL have ports: clk  in  1  system clock.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 force_reset  in  1  fault request from watchdog_timer, level.
REQ-007 warning  in  1  watchdog pre-timeout indication, level.
REQ-008 clear_fault  in  1  software acknowledge, single-cycle pulse.
REQ-009 amp_in  in  AMP_W  requested carrier amplitude, unsigned.
REQ-010 amp_out  out  AMP_W  amplitude to modulator, registered.
REQ-011 rf_enable  out  1  RF output enable, registered.
REQ-012 fault_latched  out  1  sticky fault flag.
REQ-013 fault_count  out  8  number of accepted faults, saturating.
REQ-014 state  out  3  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states RUN, RAMP_DOWN, MUTED, HOLDOFF, RAMP_UP.
REQ-016 RUN: amp_out SHALL be amp_in, or amp_in>>1 while warning=1, one-cycle registered latency.
REQ-017 force_reset=1 in RUN or RAMP_UP SHALL enter RAMP_DOWN next cycle, set fault_latched, increment fault_count (saturate at 255).
REQ-018 RAMP_DOWN: amp_out SHALL decrease by RAMP_STEP per cycle, clamped at 0 (no wrap); on the cycle amp_out reaches 0 the FSM SHALL enter MUTED.
REQ-019 MUTED: rf_enable=0, amp_out=0; force_reset=0 SHALL enter HOLDOFF with counter loaded to HOLDOFF_CYCLES-1.
REQ-020 HOLDOFF: counter SHALL decrement per cycle; force_reset=1 SHALL return to MUTED and not increment fault_count.
REQ-021 HOLDOFF with counter=0 SHALL enter RAMP_UP when the recovery condition (REQ-030/031) holds, else remain in HOLDOFF with counter held at 0.
REQ-022 RAMP_UP: rf_enable=1; amp_out SHALL increase by RAMP_STEP per cycle, clamped to current amp_in (saturating, no overflow); amp_out = amp_in SHALL enter RUN.
REQ-023 amp_in lowered during RAMP_UP below amp_out SHALL clamp amp_out to amp_in immediately and enter RUN.
REQ-024 clear_fault SHALL clear fault_latched only in RUN, RAMP_UP or HOLDOFF; ignored in RAMP_DOWN and MUTED.
REQ-025 force_reset and clear_fault in the same cycle: force_reset SHALL win.
REQ-026 warning SHALL have no effect outside RUN.

Reset
REQ-027 rstn=0 SHALL asynchronously force state=RAMP_UP, amp_out=0, rf_enable=0, fault_latched=0, fault_count=0, holdoff counter=0.
REQ-028 rf_enable SHALL assert on the first clock after rstn release; reset mid-ramp SHALL abandon the ramp with no glitch above the pre-reset amp_out.
REQ-029 Reset released with force_reset=1 SHALL enter RAMP_DOWN on the first clock (amp_out already 0, MUTED one cycle later).

Configuration
REQ-030 With AUTO_RECOVER_EN defined, the recovery condition SHALL be counter=0 alone.
REQ-031 Without AUTO_RECOVER_EN, the recovery condition SHALL be counter=0 and fault_latched=0 (clear_fault received).

Structure
REQ-032 Package amradio_safety_pkg SHALL hold the state enum and the 3-bit encodings (RUN=0 ... RAMP_UP=4).
REQ-033 Sub-module amp_ramp SHALL implement the saturating step-up/step-down toward a target; FSM and counters stay in safe_shutdown_ctrl.

Verification (AMP_W=16, RAMP_STEP=256, HOLDOFF_CYCLES=16)
REQ-034 Reset, amp_in=0x1000, no faults -> amp_out reaches 0x1000 after 16 clocks, state=RUN.
REQ-035 RUN amp_in=0x0900, force_reset 1 cycle -> amp_out 0x0800,0x0700..0 (9 steps, last clamp), MUTED, 16 HOLDOFF clocks, fault_count=1.
REQ-036 warning=1 in RUN with amp_in=0x2000 -> amp_out=0x1000 next cycle; warning drop -> 0x2000.
REQ-037 force_reset re-asserted at HOLDOFF counter=5 -> MUTED, counter reloads to 15 on release, fault_count unchanged.
REQ-038 Without AUTO_RECOVER_EN: HOLDOFF holds at 0 until clear_fault pulse, then RAMP_UP; with macro: RAMP_UP directly.
REQ-039 256 force_reset events -> fault_count stays 255; simultaneous clear_fault+force_reset -> fault_latched=1.
